mem_stage_ext: RTL and testbench

//  Parametrised MEM pipeline stage of the MIPS core: EX->MEM inputs, internal data memory, MEM->WB register.

---
 rtl/mem_stage_ext.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_ext.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_ext.sv
// rtl/mem_stage_ext.sv - MIPS MEM stage: data memory, sub-word loads/stores, wait-state FSM, MEM->WB register.
module mem_stage_ext #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter bit          TRACE_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  mem_op,
  input  logic        reg_wen_in,
  input  logic [4:0]  reg_waddr_in,
  input  logic [4:0]  raddr0_in,
  input  logic [4:0]  raddr1_in,
  input  logic [31:0] alu_out,
  input  logic [31:0] st_data,
  input  logic [31:0] pc_in,
  input  logic [2:0]  tuse0_in,
  input  logic [2:0]  tuse1_in,
  input  logic [2:0]  tnew_in,
  output logic        stall_mem,
  output logic [4:0]  raddr0_m,
  output logic [4:0]  raddr1_m,
  output logic [4:0]  waddr_m,
  output logic [2:0]  tuse0_m,
  output logic [2:0]  tuse1_m,
  output logic [2:0]  tnew_m,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc,
  output logic [2:0]  wb_tuse0,
  output logic [2:0]  wb_tuse1,
  output logic [2:0]  wb_tnew,
  output logic [1:0]  wb_exc
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                         OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

  typedef enum logic { S_IDLE, S_WAIT } state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rword, merged, load_data, wdata_next;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic              is_load, is_store, misalign, access, complete;
  logic [1:0]        exc_now;

  assign idx      = alu_out[ADDR_W+1:2];
  assign lane     = alu_out[1:0];
  assign is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
  assign is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);

  always_comb begin
    misalign = 1'b0;
    case (mem_op)
      OP_LW, OP_SW:          misalign = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misalign = lane[0];
      default:               misalign = 1'b0;
    endcase
  end

  assign exc_now   = (in_valid && misalign) ? (is_load ? 2'b01 : 2'b10) : 2'b00;
  assign access    = in_valid && (is_load || is_store) && !misalign;
  assign stall_mem = access && (WAIT_CYCLES > 0) && ((state == S_IDLE) || (cnt != 4'd0));
  assign complete  = !stall_mem;

  assign rword = mem[idx];
  assign rbyte = 8'(rword >> {lane, 3'b000});
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    case (mem_op)
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'h0000, rhalf};
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'h000000, rbyte};
      default: load_data = rword;
    endcase
    wdata_next = (access && is_load) ? load_data : alu_out;
  end

  // Byte-enable merge of store data into the currently addressed word.
  always_comb begin
    merged = rword;
    case (mem_op)
      OP_SB:   merged[{lane, 3'b000} +: 8]    = st_data[7:0];
      OP_SH:   merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
      OP_SW:   merged = st_data;
      default: merged = rword;
    endcase
  end

  function automatic logic [2:0] dec_use(input logic [2:0] x);
    return (x == 3'd7) ? 3'd7 : ((x != 3'd0) ? x - 3'd1 : 3'd0);
  endfunction

  assign raddr0_m = raddr0_in;
  assign raddr1_m = raddr1_in;
  assign waddr_m  = reg_waddr_in;
  assign tuse0_m  = dec_use(tuse0_in);
  assign tuse1_m  = dec_use(tuse1_in);
  assign tnew_m   = (tnew_in != 3'd0) ? tnew_in - 3'd1 : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (access && (WAIT_CYCLES > 0)) begin
          state <= S_WAIT;
          cnt   <= 4'(WAIT_CYCLES - 1);
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (access && complete && is_store) begin
      mem[idx] <= merged;
    end
  end

  // Stall cycles push a bubble but keep the payload fields stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'h0;
      wb_pc    <= RESET_PC;
      wb_tuse0 <= 3'b111;
      wb_tuse1 <= 3'b111;
      wb_tnew  <= 3'd0;
      wb_exc   <= 2'b00;
    end else if (stall_mem) begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      wb_exc   <= 2'b00;
    end else begin
      wb_valid <= in_valid;
      wb_wen   <= reg_wen_in && in_valid && (exc_now == 2'b00);
      wb_waddr <= reg_waddr_in;
      wb_wdata <= wdata_next;
      wb_pc    <= pc_in;
      wb_tuse0 <= tuse0_m;
      wb_tuse1 <= tuse1_m;
      wb_tnew  <= tnew_m;
      wb_exc   <= exc_now;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (TRACE_EN && !reset && access && complete && is_store)
      $display("%d@%h: *%h <= %h", $time, pc_in, {idx, 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_mem_stage_ext.sv
// tb/tb_mem_stage_ext.sv - scoreboard bench for mem_stage_ext with zero and two wait states.
module tb_mem_stage_ext;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic        reg_wen_in = 1'b0;
  logic [4:0]  reg_waddr_in = 5'd0, raddr0_in = 5'd0, raddr1_in = 5'd0;
  logic [31:0] alu_out = 32'h0, st_data = 32'h0, pc_in = 32'h0;
  logic [2:0]  tuse0_in = 3'd7, tuse1_in = 3'd7, tnew_in = 3'd0;

  logic        a_stall, b_stall, a_valid, b_valid, a_wen, b_wen;
  logic [4:0]  a_r0, a_r1, a_wa, b_r0, b_r1, b_wa, a_wbwa, b_wbwa;
  logic [2:0]  a_tu0, a_tu1, a_tn, b_tu0, b_tu1, b_tn;
  logic [2:0]  a_wtu0, a_wtu1, a_wtn, b_wtu0, b_wtu1, b_wtn;
  logic [31:0] a_wdata, b_wdata, a_pc, b_pc;
  logic [1:0]  a_exc, b_exc;

  int tests = 0, fails = 0;
  bit sel = 1'b0;

  typedef struct { string tag; logic valid; logic wen; logic [31:0] wdata; logic [1:0] exc; } exp_t;
  exp_t exp_q[$];

  localparam logic [3:0] NONE = 0, LW = 1, LH = 2, LHU = 3, LB = 4, LBU = 5, SW = 6, SH = 7, SB = 8;

  always #5 clk = ~clk;

  mem_stage_ext #(.WAIT_CYCLES(0), .TRACE_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_op(mem_op), .reg_wen_in(reg_wen_in),
    .reg_waddr_in(reg_waddr_in), .raddr0_in(raddr0_in), .raddr1_in(raddr1_in), .alu_out(alu_out),
    .st_data(st_data), .pc_in(pc_in), .tuse0_in(tuse0_in), .tuse1_in(tuse1_in), .tnew_in(tnew_in),
    .stall_mem(a_stall), .raddr0_m(a_r0), .raddr1_m(a_r1), .waddr_m(a_wa), .tuse0_m(a_tu0),
    .tuse1_m(a_tu1), .tnew_m(a_tn), .wb_valid(a_valid), .wb_wen(a_wen), .wb_waddr(a_wbwa),
    .wb_wdata(a_wdata), .wb_pc(a_pc), .wb_tuse0(a_wtu0), .wb_tuse1(a_wtu1), .wb_tnew(a_wtn),
    .wb_exc(a_exc));

  mem_stage_ext #(.WAIT_CYCLES(2), .TRACE_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_op(mem_op), .reg_wen_in(reg_wen_in),
    .reg_waddr_in(reg_waddr_in), .raddr0_in(raddr0_in), .raddr1_in(raddr1_in), .alu_out(alu_out),
    .st_data(st_data), .pc_in(pc_in), .tuse0_in(tuse0_in), .tuse1_in(tuse1_in), .tnew_in(tnew_in),
    .stall_mem(b_stall), .raddr0_m(b_r0), .raddr1_m(b_r1), .waddr_m(b_wa), .tuse0_m(b_tu0),
    .tuse1_m(b_tu1), .tnew_m(b_tn), .wb_valid(b_valid), .wb_wen(b_wen), .wb_waddr(b_wbwa),
    .wb_wdata(b_wdata), .wb_pc(b_pc), .wb_tuse0(b_wtu0), .wb_tuse1(b_wtu1), .wb_tnew(b_wtn),
    .wb_exc(b_exc));

  wire        o_stall = sel ? b_stall : a_stall;
  wire        o_valid = sel ? b_valid : a_valid;
  wire        o_wen   = sel ? b_wen   : a_wen;
  wire [31:0] o_wdata = sel ? b_wdata : a_wdata;
  wire [31:0] o_pc    = sel ? b_pc    : a_pc;
  wire [1:0]  o_exc   = sel ? b_exc   : a_exc;
  wire [2:0]  o_wtu0  = sel ? b_wtu0  : a_wtu0;
  wire [2:0]  o_wtu1  = sel ? b_wtu1  : a_wtu1;
  wire [2:0]  o_wtn   = sel ? b_wtn   : a_wtn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction, check the stall pattern, then compare the committed WB slot.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] exp_wdata,
                       input logic [1:0] exp_exc, input int wait_n);
    exp_t e;
    logic wen;
    wen = (op >= SW && op <= SB) ? 1'b0 : 1'b1;
    in_valid = 1'b1; mem_op = op; alu_out = addr; st_data = sd; reg_wen_in = wen;
    reg_waddr_in = 5'd9; pc_in = pc_in + 32'd4;
    e.tag = tag; e.valid = 1'b1; e.wen = wen && (exp_exc == 2'b00);
    e.wdata = exp_wdata; e.exc = exp_exc;
    exp_q.push_back(e);
    #1;
    for (int i = 0; i <= wait_n; i++) begin
      check({tag, ".stall"}, 32'(o_stall), 32'(i < wait_n));
      @(posedge clk); #1;
      if (i < wait_n) check({tag, ".bubble"}, {31'd0, o_valid}, 32'd0);
    end
    e = exp_q.pop_front();
    check({e.tag, ".ctl"}, {28'd0, o_valid, o_wen, o_exc}, {28'd0, e.valid, e.wen, e.exc});
    check({e.tag, ".wdata"}, o_wdata, e.wdata);
    in_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst.valid", {30'd0, o_valid, o_wen}, 32'd0);
    check("rst.pc", o_pc, 32'h0000_3000);
    check("rst.tim", {23'd0, o_wtu0, o_wtu1, o_wtn}, {23'd0, 3'd7, 3'd7, 3'd0});
    check("rst.wdata", o_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    sel = 1'b0;
    do_op("sw10",  SW,  32'h10, 32'h1234_5678, 32'h10, 2'b00, 0);
    do_op("lb11",  LB,  32'h11, 32'h0, 32'h0000_0056, 2'b00, 0);
    do_op("lbu13", LBU, 32'h13, 32'h0, 32'h0000_0012, 2'b00, 0);
    do_op("lh12",  LH,  32'h12, 32'h0, 32'h0000_1234, 2'b00, 0);
    do_op("lw10",  LW,  32'h10, 32'h0, 32'h1234_5678, 2'b00, 0);
    do_op("sh22",  SH,  32'h22, 32'h0000_BEEF, 32'h22, 2'b00, 0);
    do_op("lw20",  LW,  32'h20, 32'h0, 32'hBEEF_0000, 2'b00, 0);
    do_op("lh22",  LH,  32'h22, 32'h0, 32'hFFFF_BEEF, 2'b00, 0);
    do_op("lhu22", LHU, 32'h22, 32'h0, 32'h0000_BEEF, 2'b00, 0);
    do_op("sb21",  SB,  32'h21, 32'h0000_0080, 32'h21, 2'b00, 0);
    do_op("lb21",  LB,  32'h21, 32'h0, 32'hFFFF_FF80, 2'b00, 0);
    do_op("lw20b", LW,  32'h20, 32'h0, 32'hBEEF_8000, 2'b00, 0);
    do_op("lw6",   LW,  32'h6,  32'h0, 32'h6, 2'b01, 0);
    do_op("sw3",   SW,  32'h3,  32'hFFFF_FFFF, 32'h3, 2'b10, 0);
    do_op("lw0",   LW,  32'h0,  32'h0, 32'h0, 2'b00, 0);
    do_op("sh11",  SH,  32'h11, 32'hFFFF_FFFF, 32'h11, 2'b10, 0);
    do_op("lw10c", LW,  32'h10, 32'h0, 32'h1234_5678, 2'b00, 0);
    do_op("sw1000", SW, 32'h1000, 32'hA5A5_A5A5, 32'h1000, 2'b00, 0);
    do_op("alias",  LW, 32'h0,  32'h0, 32'hA5A5_A5A5, 2'b00, 0);

    tuse0_in = 3'd7; tuse1_in = 3'd2; tnew_in = 3'd0; raddr0_in = 5'd3; raddr1_in = 5'd4;
    #1;
    check("dec.comb", {23'd0, a_tu0, a_tu1, a_tn}, {23'd0, 3'd7, 3'd1, 3'd0});
    check("fwd.addr", {17'd0, a_r0, a_r1, a_wa}, {17'd0, 5'd3, 5'd4, 5'd9});
    do_op("addu", NONE, 32'hDEAD_0001, 32'h0, 32'hDEAD_0001, 2'b00, 0);
    check("dec.wb", {23'd0, o_wtu0, o_wtu1, o_wtn}, {23'd0, 3'd7, 3'd1, 3'd0});
    tnew_in = 3'd3; pc_in = 32'h0000_4444;
    @(posedge clk); #1;
    check("bubble.ctl", {30'd0, o_valid, o_wen}, 32'd0);
    check("bubble.pc", o_pc, 32'h0000_4444);
    check("bubble.tnew", {29'd0, o_wtn}, 32'd2);

    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    sel = 1'b1;
    do_op("w.sw40", SW, 32'h40, 32'hCAFE_F00D, 32'h40, 2'b00, 2);
    do_op("w.lw40", LW, 32'h40, 32'h0, 32'hCAFE_F00D, 2'b00, 2);
    do_op("w.addu", NONE, 32'h0000_0777, 32'h0, 32'h0000_0777, 2'b00, 0);
    do_op("w.lw6",  LW, 32'h6, 32'h0, 32'h6, 2'b01, 0);

    in_valid = 1'b1; mem_op = SW; alu_out = 32'h44; st_data = 32'h1111_1111; pc_in = 32'h0000_5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    check("rst.mid.pc", o_pc, 32'h0000_3000);
    check("rst.mid.ctl", {28'd0, o_valid, o_wen, o_exc}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    do_op("w.lw44", LW, 32'h44, 32'h0, 32'h0, 2'b00, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
